// File: rtl/cam_writer_pkg.sv
// Shared types and constants for the camera-to-frame-buffer writer.
package cam_writer_pkg;

    localparam int PIX_W             = 16;
    localparam int WORD_W            = 32;
    localparam int MAX_WORDS_DEFAULT = 42500;

    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_LOW  = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_CAPTURE,
        ST_DONE
    } cap_state_t;

endpackage

// File: rtl/cam_pix_packer.sv
// Packs RGB565 pixel pairs into 32-bit words; a flushed low pixel
// becomes a half word with the upper lanes zeroed.
module cam_pix_packer
    import cam_writer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              phase,
    input  logic              flush,
    input  logic              clear,
    input  logic [PIX_W-1:0]  pix,
    output logic [WORD_W-1:0] word,
    output logic [3:0]        byteenable,
    output logic              word_valid
);

    logic [PIX_W-1:0] low_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            low_q <= '0;
        end else if (load && !phase) begin
            low_q <= pix;
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        word       = {{PIX_W{1'b0}}, pix};
        byteenable = BE_LOW;
        word_valid = load && (phase || flush);
        if (phase) begin
            word       = {pix, low_q};
            byteenable = BE_FULL;
        end
    end

endmodule

// File: rtl/cam_frame_writer.sv
// Captures one camera frame into the on-chip frame buffer at word
// addresses 0.., with overflow and resync status for software.
module cam_frame_writer
    import cam_writer_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       cfg_words,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_sof,
    input  logic              pix_eof,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [WORD_W-1:0] ram_writedata,
    output logic              ram_clken,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] words_written,
    output logic              overflow,
    output logic              sync_err
);

    cap_state_t        state, next_state;
    logic [ADDR_W-1:0] addr, limit, cur_addr, cfg_clamped;
    logic              phase, cur_phase;
    logic              start_go, frame_pix, restart, room, store, dropped, eof_hit;
    logic [WORD_W-1:0] pk_word;
    logic [3:0]        pk_be;
    logic              pk_valid;

    // The buffer never stalls, so every offered pixel is taken.
    assign pix_ready = 1'b1;
    assign ram_clken = 1'b1;

    // A pix_sof pixel restarts the frame: it is pixel 0 at word 0.
    always_comb begin
        cfg_clamped = (32'(cfg_words) > 32'(MAX_WORDS)) ? ADDR_W'(MAX_WORDS)
                                                         : ADDR_W'(cfg_words);
        start_go  = (state == ST_IDLE) && start && !abort;
        frame_pix = pix_valid && !abort &&
                    ((state == ST_CAPTURE) || ((state == ST_WAIT_SOF) && pix_sof));
        restart   = frame_pix && pix_sof;
        cur_addr  = restart ? '0 : addr;
        cur_phase = restart ? 1'b0 : phase;
        room      = cur_addr < limit;
        store     = frame_pix && room;
        dropped   = frame_pix && !room;
        eof_hit   = frame_pix && pix_eof;
    end

    cam_pix_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .load       (store),
        .phase      (cur_phase),
        .flush      (pix_eof),
        .clear      (start_go || abort),
        .pix        (pix_data),
        .word       (pk_word),
        .byteenable (pk_be),
        .word_valid (pk_valid)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (start_go) next_state = ST_WAIT_SOF;
            ST_WAIT_SOF,
            ST_CAPTURE:  if (eof_hit) next_state = ST_DONE;
                         else if (frame_pix) next_state = ST_CAPTURE;
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
        if (abort) next_state = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            addr           <= '0;
            limit          <= '0;
            phase          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            words_written  <= '0;
            overflow       <= 1'b0;
            sync_err       <= 1'b0;
            ram_address    <= '0;
            ram_byteenable <= '0;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            ram_writedata  <= '0;
        end else begin
            state          <= next_state;
            busy           <= (next_state == ST_WAIT_SOF) || (next_state == ST_CAPTURE);
            done           <= eof_hit;
            ram_chipselect <= pk_valid;
            ram_write      <= pk_valid;
            ram_byteenable <= pk_valid ? pk_be : 4'b0000;

            if (start_go) begin
                limit         <= cfg_clamped;
                addr          <= '0;
                phase         <= 1'b0;
                words_written <= '0;
                overflow      <= 1'b0;
                sync_err      <= 1'b0;
            end

            // The count advances with the strobe, so done sees the final total.
            if (pk_valid) begin
                ram_address   <= cur_addr;
                ram_writedata <= pk_word;
                addr          <= cur_addr + ADDR_W'(1);
                words_written <= cur_addr + ADDR_W'(1);
            end else if (restart) begin
                addr          <= '0;
                words_written <= '0;
            end

            if (store) begin
                phase <= !cur_phase;
            end else if (restart) begin
                phase <= 1'b0;
            end

            if (dropped) overflow <= 1'b1;
            if (restart && (state == ST_CAPTURE)) sync_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Bench for cam_frame_writer: frame-level reference model compared every
// cycle, directed frames with literal expectations, then random traffic.
module tb_cam_frame_writer;

    localparam int MAXW = 42500;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [15:0] cfg_words;
    logic        pix_valid, pix_ready, pix_sof, pix_eof;
    logic [15:0] pix_data;
    logic [15:0] ram_address, words_written;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata;
    logic        busy, done, overflow, sync_err;

    always #5 clk = ~clk;

    cam_frame_writer #(.MAX_WORDS(MAXW), .ADDR_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .cfg_words      (cfg_words),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_data       (pix_data),
        .pix_sof        (pix_sof),
        .pix_eof        (pix_eof),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .busy           (busy),
        .done           (done),
        .words_written  (words_written),
        .overflow       (overflow),
        .sync_err       (sync_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame is a list of pixels; pixel n lands in word
    // n/2 and is kept only while n/2 is below the latched word limit.
    typedef enum {M_IDLE, M_ARMED, M_CAP, M_DONE} mstate_t;
    mstate_t     m_st;
    int unsigned m_limit;
    int          m_n;
    logic [15:0] frame_q[$];
    logic        e_write, e_done, e_busy, e_ovf, e_serr;
    logic [15:0] e_addr, e_ww;
    logic [31:0] e_data;
    logic [3:0]  e_be;

    always @(posedge clk) begin
        e_write = 1'b0;
        e_done  = 1'b0;
        if (reset) begin
            m_st = M_IDLE; m_limit = 0; frame_q.delete();
            e_ww = '0; e_ovf = 1'b0; e_serr = 1'b0;
            e_addr = '0; e_data = '0; e_be = '0;
        end else if (abort) begin
            m_st = M_IDLE;
            frame_q.delete();
        end else begin
            case (m_st)
                M_IDLE: if (start) begin
                    m_limit = (int'(cfg_words) > MAXW) ? MAXW : int'(cfg_words);
                    e_ww = '0; e_ovf = 1'b0; e_serr = 1'b0;
                    frame_q.delete();
                    m_st = M_ARMED;
                end
                M_DONE: m_st = M_IDLE;
                default: if (pix_valid && (m_st == M_CAP || pix_sof)) begin
                    if (pix_sof) begin
                        if (m_st == M_CAP) e_serr = 1'b1;
                        frame_q.delete();
                        e_ww = '0;
                    end
                    m_n = frame_q.size();
                    frame_q.push_back(pix_data);
                    if (m_n / 2 < m_limit) begin
                        if (m_n % 2 == 1) begin
                            e_write = 1'b1; e_addr = 16'(m_n / 2);
                            e_data = {frame_q[m_n], frame_q[m_n-1]}; e_be = 4'hF;
                        end else if (pix_eof) begin
                            e_write = 1'b1; e_addr = 16'(m_n / 2);
                            e_data = {16'h0000, frame_q[m_n]}; e_be = 4'h3;
                        end
                        if (e_write) e_ww = e_addr + 16'd1;
                    end else begin
                        e_ovf = 1'b1;
                    end
                    if (pix_eof) begin
                        m_st = M_DONE; e_done = 1'b1;
                    end else begin
                        m_st = M_CAP;
                    end
                end
            endcase
        end
        e_busy = (m_st == M_ARMED) || (m_st == M_CAP);
    end

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;
    wr_t         wlog[$];
    int          done_cnt;
    logic        done_w;
    logic [15:0] done_a;

    function automatic wr_t log_at(input int k);
        if (k < wlog.size()) return wlog[k];
        return '0;
    endfunction

    // Compare process: DUT against model every cycle, plus write/done log.
    always @(posedge clk) begin
        wr_t w;
        #1;
        check("ram_write", ram_write, e_write);
        check("ram_chipselect", ram_chipselect, e_write);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("words_written", words_written, e_ww);
        check("overflow", overflow, e_ovf);
        check("sync_err", sync_err, e_serr);
        check("ready_clken", {pix_ready, ram_clken}, 2'b11);
        if (e_write) begin
            check("ram_address", ram_address, e_addr);
            check("ram_writedata", ram_writedata, e_data);
            check("ram_byteenable", ram_byteenable, e_be);
        end
        if (ram_write) begin
            w.a = ram_address; w.d = ram_writedata; w.be = ram_byteenable;
            wlog.push_back(w);
        end
        if (done) begin
            done_cnt++; done_w = ram_write; done_a = ram_address;
        end
    end

    task automatic clear_log();
        wlog.delete();
        done_cnt = 0; done_w = 1'b0; done_a = '0;
    endtask

    task automatic quiet();
        start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0;
    endtask

    task automatic idle(input int n);
        quiet();
        repeat (n) @(negedge clk);
    endtask

    task automatic arm(input logic [15:0] cfg);
        quiet(); start = 1'b1; cfg_words = cfg;
        @(negedge clk);
        quiet();
    endtask

    task automatic pix(input logic [15:0] d, input logic s, input logic e);
        quiet(); pix_valid = 1'b1; pix_data = d; pix_sof = s; pix_eof = e;
        @(negedge clk);
        quiet();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, {ram_write, ram_chipselect, ram_byteenable, busy, done,
                              overflow, sync_err}, 10'b0);
        check({tag, "_addr"}, ram_address, 16'h0000);
        check({tag, "_data"}, ram_writedata, 32'h0000_0000);
        check({tag, "_ww"}, words_written, 16'h0000);
        check({tag, "_ready"}, {pix_ready, ram_clken}, 2'b11);
    endtask

    initial begin
        reset = 1'b1; cfg_words = '0; pix_data = '0;
        quiet();
        clear_log();
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        idle(2);

        // Full frame of 8 pixels into 4 words.
        clear_log();
        arm(16'd4);
        for (int i = 1; i <= 8; i++) pix(16'(i), i == 1, i == 8);
        idle(3);
        check("full_nwr", wlog.size(), 4);
        check("full_w0", log_at(0), {16'd0, 32'h0002_0001, 4'hF});
        check("full_w1", log_at(1), {16'd1, 32'h0004_0003, 4'hF});
        check("full_w2", log_at(2), {16'd2, 32'h0006_0005, 4'hF});
        check("full_w3", log_at(3), {16'd3, 32'h0008_0007, 4'hF});
        check("full_done", {done_cnt[7:0], done_w, done_a}, {8'd1, 1'b1, 16'd3});
        check("full_ww", words_written, 16'd4);

        // Odd pixel count ends with a half word.
        clear_log();
        arm(16'd4);
        for (int i = 1; i <= 5; i++) pix(16'(i), i == 1, i == 5);
        idle(3);
        check("odd_w2", log_at(2), {16'd2, 32'h0000_0005, 4'h3});
        check("odd_ww", words_written, 16'd3);
        check("odd_done", done_cnt, 1);

        // Overflow past a 2-word limit.
        clear_log();
        arm(16'd2);
        for (int i = 1; i <= 4; i++) pix(16'(i), i == 1, 1'b0);
        check("ovf_before", overflow, 1'b0);
        pix(16'd5, 1'b0, 1'b0);
        check("ovf_after5", overflow, 1'b1);
        pix(16'd6, 1'b0, 1'b1);
        idle(3);
        check("ovf_nwr", wlog.size(), 2);
        check("ovf_last", log_at(1), {16'd1, 32'h0004_0003, 4'hF});
        check("ovf_done", {done_cnt[7:0], done_w}, {8'd1, 1'b0});

        // Resync inside a frame.
        clear_log();
        arm(16'd8);
        pix(16'h0011, 1'b1, 1'b0); pix(16'h0012, 1'b0, 1'b0); pix(16'h0013, 1'b0, 1'b0);
        pix(16'h0021, 1'b1, 1'b0); pix(16'h0022, 1'b0, 1'b1);
        idle(3);
        check("rsync_err", sync_err, 1'b1);
        check("rsync_last", log_at(1), {16'd0, 32'h0022_0021, 4'hF});
        check("rsync_ww", words_written, 16'd1);

        // Abort mid-frame, then a clean capture.
        arm(16'd8);
        pix(16'd1, 1'b1, 1'b0); pix(16'd2, 1'b0, 1'b0); pix(16'd3, 1'b0, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        quiet();
        check("abort_busy", busy, 1'b0);
        clear_log();
        pix(16'd4, 1'b0, 1'b1);
        idle(4);
        check("abort_quiet", {wlog.size() == 0, done_cnt == 0}, 2'b11);
        arm(16'd8);
        pix(16'h000A, 1'b1, 1'b0); pix(16'h000B, 1'b0, 1'b1);
        idle(3);
        check("rearm_w0", log_at(0), {16'd0, 32'h000B_000A, 4'hF});

        // Gating: ignored pixels before start and before sof, gaps inside.
        clear_log();
        pix(16'h0077, 1'b1, 1'b1); pix(16'h0078, 1'b1, 1'b0);
        arm(16'd4);
        pix(16'h0055, 1'b0, 1'b0); pix(16'h0056, 1'b0, 1'b1);
        check("gate_busy", {busy, wlog.size() == 0}, 2'b11);
        pix(16'h0031, 1'b1, 1'b0); idle(2);
        pix(16'h0032, 1'b0, 1'b0); idle(1);
        pix(16'h0033, 1'b0, 1'b0); pix(16'h0034, 1'b0, 1'b1);
        idle(3);
        check("gate_nwr", wlog.size(), 2);
        check("gate_w0", log_at(0), {16'd0, 32'h0032_0031, 4'hF});
        check("gate_w1", log_at(1), {16'd1, 32'h0034_0033, 4'hF});

        // Zero-size frame: every pixel overflows, no writes, still done.
        clear_log();
        arm(16'd0);
        pix(16'd7, 1'b1, 1'b0); pix(16'd8, 1'b0, 1'b1);
        idle(3);
        check("zero_nwr", wlog.size(), 0);
        check("zero_done_ovf", {done_cnt[7:0], overflow}, {8'd1, 1'b1});

        // Abort beats start.
        start = 1'b1; abort = 1'b1; cfg_words = 16'd4;
        @(negedge clk);
        quiet();
        check("abort_start", busy, 1'b0);

        // Reset mid-capture.
        arm(16'd4);
        pix(16'd1, 1'b1, 1'b0); pix(16'd2, 1'b0, 1'b0); pix(16'd3, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("midreset");
        reset = 1'b0;
        idle(2);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 599) == 0);
            start     = ($urandom_range(0, 11) == 0);
            abort     = ($urandom_range(0, 79) == 0);
            cfg_words = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 6));
            pix_valid = ($urandom_range(0, 9) < 6);
            pix_data  = 16'($urandom);
            pix_sof   = ($urandom_range(0, 9) == 0);
            pix_eof   = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
